// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin MUX arbiter.
// State encoding is fixed so that waveforms and downstream tools agree on values.
package mux_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN1 = 2'b01,
      OWN2 = 2'b10
   } arb_state_t;

   localparam int DEFAULT_WIDTH     = 8;
   localparam int DEFAULT_MAX_BURST = 4;
   localparam int BEAT_CNT_W        = 8;

   // Map a MUX select value onto the ownership state it implies.
   function automatic arb_state_t owner_state(input logic sel);
      return sel ? OWN2 : OWN1;
   endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// Requester, consumer and MUX-select signals of the arbiter bundled into one interface.
// master = arbiter side, slave = sources/consumer side.
interface mux_arbiter_if
   import mux_arb_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             req1;
   logic [WIDTH-1:0] data1;
   logic             ack1;
   logic             req2;
   logic [WIDTH-1:0] data2;
   logic             ack2;
   logic             out_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             selection;
   logic             busy;

   modport master (
      input  req1, data1, req2, data2, out_ready,
      output ack1, ack2, out_valid, out_data, selection, busy
   );

   modport slave (
      output req1, data1, req2, data2, out_ready,
      input  ack1, ack2, out_valid, out_data, selection, busy
   );

endinterface

// File: rtl/mux_arbiter_mux.sv
// Plain 2:1 data MUX shared by the two requesters; select 0 picks input1.
module mux_arbiter_mux
   import mux_arb_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] input1,
   input  logic [WIDTH-1:0] input2,
   output logic [WIDTH-1:0] out
);

   assign out = sel ? input2 : input1;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter owning the select line of a 2:1 MUX, bursts capped at MAX_BURST beats.
// Define MUX_ARB_FIXED_PRIORITY_EN to give requester 1 fixed priority (no round-robin, no burst cap on requester 1).
module mux_arbiter
   import mux_arb_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
   input  logic          clk,
   input  logic          rst,
   mux_arbiter_if.master bus
);

   localparam logic [BEAT_CNT_W-1:0] BURST_LIM = BEAT_CNT_W'(MAX_BURST);

   arb_state_t            state;
   logic                  selection;
   logic                  last_sel;
   logic [BEAT_CNT_W-1:0] beat_cnt;

   logic                  owner_req;
   logic                  other_req;
   logic                  out_valid;
   logic                  xfer;
   logic [BEAT_CNT_W-1:0] cnt_inc;
   logic                  burst_done;
   logic                  yield_ok;
   logic                  tie_sel;
   logic                  grant_sel;

   always_comb begin
      owner_req = 1'b0;
      other_req = 1'b0;
      case (state)
         OWN1: begin
            owner_req = bus.req1;
            other_req = bus.req2;
         end
         OWN2: begin
            owner_req = bus.req2;
            other_req = bus.req1;
         end
         default: ;
      endcase
   end

`ifdef MUX_ARB_FIXED_PRIORITY_EN
   assign tie_sel  = 1'b0;
   assign yield_ok = (state == OWN2);
`else
   assign tie_sel  = ~last_sel;
   assign yield_ok = 1'b1;
`endif

   // owner_req is 0 in IDLE, so no beat can ever be offered there
   assign out_valid  = ~rst & owner_req;
   assign xfer       = out_valid & bus.out_ready;
   assign cnt_inc    = beat_cnt + 1'b1;
   assign burst_done = xfer && (cnt_inc == BURST_LIM);
   assign grant_sel  = (bus.req1 && bus.req2) ? tie_sel : bus.req2;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         selection <= 1'b0;
         last_sel  <= 1'b1;
         beat_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req1 || bus.req2) begin
                  state     <= owner_state(grant_sel);
                  selection <= grant_sel;
                  last_sel  <= grant_sel;
                  beat_cnt  <= '0;
               end
            end
            OWN1, OWN2: begin
               // Owner release wins over everything; selection is left where it was
               if (!owner_req) begin
                  state    <= IDLE;
                  beat_cnt <= '0;
               end else if (burst_done) begin
                  beat_cnt <= '0;
                  if (other_req && yield_ok) begin
                     state     <= owner_state(~selection);
                     selection <= ~selection;
                     last_sel  <= ~selection;
                  end
               end else if (xfer) begin
                  beat_cnt <= cnt_inc;
               end
            end
            default: begin
               state    <= IDLE;
               beat_cnt <= '0;
            end
         endcase
      end
   end

   assign bus.out_valid = out_valid;
   assign bus.ack1      = xfer && (state == OWN1);
   assign bus.ack2      = xfer && (state == OWN2);
   assign bus.busy      = ~rst & (state != IDLE);
   assign bus.selection = selection;

   mux_arbiter_mux #(
      .WIDTH (WIDTH)
   ) u_mux (
      .sel    (selection),
      .input1 (bus.data1),
      .input2 (bus.data2),
      .out    (bus.out_data)
   );

endmodule

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
- Round-robin arbiter that shares the 8-bit 2:1 MUX datapath between two requesters.
- Owns the MUX `Selection` line and steers the granted requester's data to one downstream consumer over a valid/ready handshake.
- Holds a grant for bursts of up to `MAX_BURST` beats, then yields if the other side is waiting.
- Instantiated between the two data sources and the MUX; drives the MUX select input.

Parameters:
- WIDTH, 8, data width of each requester and of `OutData`; matches MUX width.
- MAX_BURST, 4, maximum beats per grant before a forced yield to a waiting requester; legal range 1..255.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req1  in  1  requester 1 has a beat available.
- Data1  in  WIDTH  requester 1 data; MUX Input1.
- Ack1  out  1  requester 1 beat accepted this cycle.
- Req2  in  1  requester 2 has a beat available.
- Data2  in  WIDTH  requester 2 data; MUX Input2.
- Ack2  out  1  requester 2 beat accepted this cycle.
- OutReady  in  1  consumer can accept a beat.
- OutValid  out  1  `OutData` holds a valid beat.
- OutData  out  WIDTH  MUX output (granted requester's data).
- Selection  out  1  MUX select, registered; 0 = requester 1, 1 = requester 2.
- Busy  out  1  high whenever state is not IDLE.

Behaviour:
- Registered state:
  - `State` ∈ {IDLE, OWN1, OWN2}.
  - `Selection`.
  - `LastSel`: last requester granted.
  - `BeatCnt`: 8-bit count of beats transferred in the current grant.
- Reset values: State=IDLE, Selection=0, LastSel=1 (requester 1 wins the first tie), BeatCnt=0.
- Outputs forced 0 while `Reset`=1: OutValid, Ack1, Ack2, Busy.
- Combinational outputs:
  - OutValid = (State==OWN1 && Req1) || (State==OWN2 && Req2).
  - OutData = Selection ? Data2 : Data1.
  - Transfer (`Xfer`) = OutValid && OutReady.
  - AckN = Xfer && owner==N.
- IDLE:
  - Req1 only → OWN1, Selection=0.
  - Req2 only → OWN2, Selection=1.
  - Both → grant the requester ≠ LastSel.
  - Neither → stay IDLE.
  - On any grant: BeatCnt=0, LastSel=new owner.
  - No beat ever transfers in IDLE.
- Latency: Req rising in IDLE at cycle N → State/Selection change at N+1 → earliest Ack at N+1.
- OWNn:
  - Each Xfer increments BeatCnt.
  - Owner's Req low this cycle → IDLE next cycle. Selection holds its value; BeatCnt is cleared.
  - Xfer makes BeatCnt reach MAX_BURST and the other Req=1 → switch directly to the other OWN state next cycle. Selection flips, BeatCnt=0, LastSel updated. No idle bubble.
  - BeatCnt reaches MAX_BURST and the other Req=0 → BeatCnt=0, stay in OWNn.
- OutReady=0: no Xfer, BeatCnt unchanged, grant held. Requester may drop Req; it is not required to hold.
- Non-owner Req is ignored until yield or release.
- Simultaneous owner-drop and other-Req: IDLE first, then grant the next cycle (one-cycle bubble). Deterministic.
- Reset mid-burst: any beat presented in the reset cycle is not acknowledged; next cycle is IDLE.

Optional Feature:
- Macro: `MUX_ARB_FIXED_PRIORITY_EN`.
- Defined:
  - IDLE ties always go to requester 1; LastSel is ignored.
  - MAX_BURST yield applies only in OWN2. Requester 1 holds the grant for as long as it keeps Req1 high.
- Undefined: round-robin as above.

Decomposition:
- Shared package `mux_arb_pkg`:
  - State encoding typedef (IDLE=2'b00, OWN1=2'b01, OWN2=2'b10).
  - Default WIDTH and MAX_BURST constants.
  - Beat-counter width constant (8).
- Sub-module: instantiate the existing 2:1 MUX for `OutData`, driven by the registered `Selection`. No other sub-modules.

Test Plan:
- Reset then Req1=1, OutReady=1, Data1=8'hA5:
  - cycle 1: State=OWN1, Selection=0, OutData=A5, Ack1=1.
  - one Ack per cycle thereafter.
- Both Req high from reset, MAX_BURST=4, OutReady=1:
  - exactly 4 Ack1 (Selection=0), then 4 Ack2 (Selection=1), alternating.
  - no gap cycle at the switches.
- OWN1 with OutReady=0 for 3 cycles, Req2=1:
  - Ack1=0, BeatCnt frozen, Selection stays 0.
  - after OutReady=1, remaining burst completes before switching.
- OWN2 and Req2 falls at cycle N while Req1=1:
  - IDLE at N+1, OWN1 at N+2, Ack1 at N+2.
- Reset asserted on the 2nd beat of a burst:
  - Ack/OutValid low that cycle.
  - next cycle IDLE, Selection=0, Busy=0.
- With `MUX_ARB_FIXED_PRIORITY_EN`, both Req high for 20 cycles:
  - 20 Ack1, 0 Ack2, Selection stays 0.
